// File: rtl/ucaspian_neuron_seq.sv
// ucaspian_neuron_seq
//   Sequences time steps for a neuron core. Accepts step/clear commands,
//   holds neuron clears until the core acknowledges, issues next_step
//   pulses, and waits for a run of quiet cycles before counting a step as
//   complete. Host fires and dendrite charges share one neuron input
//   stream through a round-robin arbiter.
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   cmd_op/cmd_count/cmd_vld/rdy  command: 0 step N, 1 clear act, 2 clear cfg, 3 nop
//   host_* / dend_*               two input streams (addr, signed charge)
//   neuron_*                      arbitrated output stream
//   clear_act, clear_config       clear requests, held until clear_done
//   next_step                     one-cycle step pulse
//   step_done                     neuron idle indication
//   cur_time                      completed-step counter
//   step_evt                      one-cycle pulse when a step command finishes
//   busy                          state is not IDLE
//   dbg_state                     current FSM state (0 IDLE,1 CLEAR,2 STEP,3 DRAIN)
//
// Handshakes: a transfer happens on a rising clock edge where vld && rdy.
// A source holds vld and its payload stable from assertion until that edge.
module ucaspian_neuron_seq #(
  parameter int QUIET  = 3,
  parameter int TIME_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          cmd_op,
  input  logic [7:0]          cmd_count,
  input  logic                cmd_vld,
  output logic                cmd_rdy,
  input  logic [7:0]          host_addr,
  input  logic signed [15:0]  host_charge,
  input  logic                host_vld,
  output logic                host_rdy,
  input  logic [7:0]          dend_addr,
  input  logic signed [15:0]  dend_charge,
  input  logic                dend_vld,
  output logic                dend_rdy,
  output logic [7:0]          neuron_addr,
  output logic signed [15:0]  neuron_charge,
  output logic                neuron_vld,
  input  logic                neuron_rdy,
  output logic                clear_act,
  output logic                clear_config,
  input  logic                clear_done,
  output logic                next_step,
  input  logic                step_done,
  output logic [TIME_W-1:0]   cur_time,
  output logic                step_evt,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  localparam int QW = $clog2(QUIET + 1);
  localparam logic [QW-1:0] QUIET_V = QW'(QUIET);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_STEP  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          remaining_q, remaining_d;
  logic [QW-1:0]       quiet_q, quiet_d;
  logic [TIME_W-1:0]   time_q, time_d;
  logic                next_step_q, next_step_d;
  logic                step_evt_q, step_evt_d;
  logic                clear_act_q, clear_act_d;
  logic                clear_config_q, clear_config_d;
  logic                lock_q, lock_d;
  logic                lock_sel_q, lock_sel_d;   // 1 = dend holds the lock
  logic                prio_q, prio_d;           // 1 = dend has priority
  logic                sel_dend;
  logic                arb_en;
  logic                cmd_hs;
  logic                quiet_cycle;

  assign cmd_rdy      = (state_q == S_IDLE);
  assign cmd_hs       = cmd_vld && cmd_rdy;
  assign busy         = (state_q != S_IDLE);
  assign dbg_state    = state_q;
  assign next_step    = next_step_q;
  assign step_evt     = step_evt_q;
  assign clear_act    = clear_act_q;
  assign clear_config = clear_config_q;
  assign cur_time     = time_q;

  // ---------------- arbiter ----------------
  // Stream is closed while clearing or issuing a step, and while reset is
  // held so nothing leaks out before the registers are initialised.
  assign arb_en = !reset && ((state_q == S_IDLE) || (state_q == S_DRAIN));

  always_comb begin
    if (lock_q)                    sel_dend = lock_sel_q;
    else if (host_vld && dend_vld) sel_dend = prio_q;
    else                           sel_dend = dend_vld;
  end

  assign neuron_vld    = arb_en && (sel_dend ? dend_vld : host_vld);
  assign neuron_addr   = sel_dend ? dend_addr   : host_addr;
  assign neuron_charge = sel_dend ? dend_charge : host_charge;
  assign host_rdy      = arb_en && !sel_dend && neuron_rdy;
  assign dend_rdy      = arb_en &&  sel_dend && neuron_rdy;

  // A stalled offer keeps its grant; a completed one hands priority over.
  always_comb begin
    lock_d     = lock_q;
    lock_sel_d = lock_sel_q;
    prio_d     = prio_q;
    if (neuron_vld && !neuron_rdy) begin
      lock_d     = 1'b1;
      lock_sel_d = sel_dend;
    end else if (neuron_vld && neuron_rdy) begin
      lock_d = 1'b0;
      prio_d = !sel_dend;
    end
  end

  // ---------------- sequencer ----------------
  assign quiet_cycle = step_done && !host_vld && !dend_vld && !neuron_vld;

  always_comb begin
    state_d        = state_q;
    remaining_d    = remaining_q;
    quiet_d        = quiet_q;
    time_d         = time_q;
    next_step_d    = 1'b0;
    step_evt_d     = 1'b0;
    clear_act_d    = clear_act_q;
    clear_config_d = clear_config_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_hs) begin
          case (cmd_op)
            2'd0: begin
              if (cmd_count != 8'd0) begin
                remaining_d = cmd_count;
                state_d     = S_STEP;
                next_step_d = 1'b1;
              end
            end
            2'd1: begin
              clear_act_d = 1'b1;
              state_d     = S_CLEAR;
            end
            2'd2: begin
              clear_config_d = 1'b1;
              state_d        = S_CLEAR;
            end
            default: ;
          endcase
        end
      end
      S_CLEAR: begin
        // clear_done is only looked at from inside CLEAR, so the clear is
        // always visible for at least one cycle.
        if (clear_done) begin
          clear_act_d    = 1'b0;
          clear_config_d = 1'b0;
          time_d         = '0;
          state_d        = S_IDLE;
        end
      end
      S_STEP: begin
        quiet_d = '0;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        quiet_d = quiet_cycle ? quiet_q + QW'(1) : '0;
        if (quiet_d == QUIET_V) begin
          quiet_d     = '0;
          time_d      = time_q + TIME_W'(1);
          remaining_d = remaining_q - 8'd1;
          if (remaining_q != 8'd1) begin
            state_d     = S_STEP;
            next_step_d = 1'b1;
          end else begin
            state_d    = S_IDLE;
            step_evt_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      remaining_q    <= '0;
      quiet_q        <= '0;
      time_q         <= '0;
      next_step_q    <= 1'b0;
      step_evt_q     <= 1'b0;
      clear_act_q    <= 1'b0;
      clear_config_q <= 1'b0;
      lock_q         <= 1'b0;
      lock_sel_q     <= 1'b0;
      prio_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      remaining_q    <= remaining_d;
      quiet_q        <= quiet_d;
      time_q         <= time_d;
      next_step_q    <= next_step_d;
      step_evt_q     <= step_evt_d;
      clear_act_q    <= clear_act_d;
      clear_config_q <= clear_config_d;
      lock_q         <= lock_d;
      lock_sel_q     <= lock_sel_d;
      prio_q         <= prio_d;
    end
  end

endmodule

// File: tb/tb_ucaspian_neuron_seq.sv
// Bench for ucaspian_neuron_seq. Inputs change and outputs are read at the
// falling clock edge. A second instance with a 4-bit time counter shares all
// inputs so counter wrap can be observed.
module tb_ucaspian_neuron_seq;
  localparam int QUIET = 3;
  localparam int PER   = QUIET + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic [1:0]         cmd_op;
  logic [7:0]         cmd_count;
  logic               cmd_vld, cmd_rdy;
  logic [7:0]         host_addr, dend_addr, neuron_addr;
  logic signed [15:0] host_charge, dend_charge, neuron_charge;
  logic               host_vld, host_rdy, dend_vld, dend_rdy, neuron_vld, neuron_rdy;
  logic               clear_act, clear_config, clear_done, next_step, step_done;
  logic [15:0]        cur_time;
  logic               step_evt, busy;
  logic [1:0]         dbg_state;

  logic               cmd_rdy4, host_rdy4, dend_rdy4, neuron_vld4;
  logic [7:0]         neuron_addr4;
  logic signed [15:0] neuron_charge4;
  logic               clear_act4, clear_config4, next_step4, step_evt4, busy4;
  logic [3:0]         cur_time4;
  logic [1:0]         dbg_state4;

  ucaspian_neuron_seq #(.QUIET(QUIET), .TIME_W(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .host_addr(host_addr), .host_charge(host_charge), .host_vld(host_vld), .host_rdy(host_rdy),
    .dend_addr(dend_addr), .dend_charge(dend_charge), .dend_vld(dend_vld), .dend_rdy(dend_rdy),
    .neuron_addr(neuron_addr), .neuron_charge(neuron_charge), .neuron_vld(neuron_vld),
    .neuron_rdy(neuron_rdy),
    .clear_act(clear_act), .clear_config(clear_config), .clear_done(clear_done),
    .next_step(next_step), .step_done(step_done), .cur_time(cur_time),
    .step_evt(step_evt), .busy(busy), .dbg_state(dbg_state)
  );

  ucaspian_neuron_seq #(.QUIET(QUIET), .TIME_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy4),
    .host_addr(host_addr), .host_charge(host_charge), .host_vld(host_vld), .host_rdy(host_rdy4),
    .dend_addr(dend_addr), .dend_charge(dend_charge), .dend_vld(dend_vld), .dend_rdy(dend_rdy4),
    .neuron_addr(neuron_addr4), .neuron_charge(neuron_charge4), .neuron_vld(neuron_vld4),
    .neuron_rdy(neuron_rdy),
    .clear_act(clear_act4), .clear_config(clear_config4), .clear_done(clear_done),
    .next_step(next_step4), .step_done(step_done), .cur_time(cur_time4),
    .step_evt(step_evt4), .busy(busy4), .dbg_state(dbg_state4)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int model_time = 0;   // completed steps since last clear/reset, unbounded

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [1:0] op, input logic [7:0] cnt);
    int waited;
    waited    = 0;
    cmd_op    = op;
    cmd_count = cnt;
    cmd_vld   = 1'b1;
    while (!cmd_rdy && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (cmd_rdy !== 1'b1) $display("FAIL cmd_accept: cmd_rdy=%b required 1 within 100 cycles", cmd_rdy);
    else n_pass++;
    @(negedge clk);
    cmd_vld = 1'b0;
  endtask

  // Step command of n steps with no traffic: pulses every PER cycles starting
  // the cycle after acceptance, step_evt one period after the last pulse.
  task automatic run_steps(input int n);
    int ns_cnt, bad_space, evt_at, evt_cnt, last_ns;
    ns_cnt = 0; bad_space = 0; evt_at = -1; evt_cnt = 0; last_ns = -1;
    step_done = 1'b1;
    send_cmd(2'd0, 8'(n));
    for (int c = 0; c <= n * PER + 3; c++) begin
      if (next_step) begin
        if (ns_cnt == 0 && c != 0) bad_space++;
        if (ns_cnt > 0 && c - last_ns != PER) bad_space++;
        last_ns = c;
        ns_cnt++;
      end
      if (step_evt) begin
        evt_cnt++;
        if (evt_at < 0) evt_at = c;
      end
      if (c == n * PER) begin
        model_time = (model_time + n) % 65536;
        n_checks++;
        if (cur_time !== 16'(model_time)) $display("FAIL step_time: cur_time=%0d required %0d", cur_time, model_time);
        else n_pass++;
        n_checks++;
        if (cur_time4 !== 4'(model_time % 16)) $display("FAIL step_time4: cur_time=%0d required %0d", cur_time4, model_time % 16);
        else n_pass++;
        n_checks++;
        if (cmd_rdy !== 1'b1) $display("FAIL step_cmd_rdy: cmd_rdy=%b required 1", cmd_rdy);
        else n_pass++;
        n_checks++;
        if (step_evt4 !== 1'b1) $display("FAIL step_evt4: step_evt=%b required 1", step_evt4);
        else n_pass++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (ns_cnt !== n) $display("FAIL step_pulses: got %0d pulses required %0d", ns_cnt, n);
    else n_pass++;
    n_checks++;
    if (bad_space !== 0) $display("FAIL step_spacing: %0d misplaced pulses required 0", bad_space);
    else n_pass++;
    n_checks++;
    if (evt_cnt !== 1) $display("FAIL step_evt_count: got %0d required 1", evt_cnt);
    else n_pass++;
    n_checks++;
    if (evt_at !== n * PER) $display("FAIL step_evt_cycle: got %0d required %0d", evt_at, n * PER);
    else n_pass++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; cmd_vld = 1'b0; cmd_op = 2'd0; cmd_count = 8'd0;
    host_vld = 1'b1; dend_vld = 1'b1; neuron_rdy = 1'b1;
    host_addr = 8'h11; host_charge = 16'sd5; dend_addr = 8'h22; dend_charge = -16'sd7;
    clear_done = 1'b0; step_done = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({neuron_vld, host_rdy, dend_rdy} !== 3'b000) $display("FAIL reset_gate: vld/hrdy/drdy=%b required 000", {neuron_vld, host_rdy, dend_rdy});
    else n_pass++;
    n_checks++;
    if ({cmd_rdy, busy} !== 2'b10) $display("FAIL reset_rdy_busy: got %b required 10", {cmd_rdy, busy});
    else n_pass++;
    n_checks++;
    if (cur_time !== 16'd0) $display("FAIL reset_time: cur_time=%0d required 0", cur_time);
    else n_pass++;
    n_checks++;
    if ({next_step, step_evt, clear_act, clear_config} !== 4'b0000) $display("FAIL reset_pulses: got %b required 0000", {next_step, step_evt, clear_act, clear_config});
    else n_pass++;
    reset = 1'b0; host_vld = 1'b0; dend_vld = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_arb_fair();
    int src, stable_bad;
    logic [23:0] hold;
    stable_bad = 0;
    host_addr = 8'($urandom_range(0, 255)); host_charge = 16'($urandom);
    dend_addr = 8'($urandom_range(0, 255)); dend_charge = 16'($urandom);
    host_vld = 1'b1; dend_vld = 1'b1; neuron_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      src = host_rdy ? 0 : (dend_rdy ? 1 : -1);
      n_checks++;
      if (src !== i % 2) $display("FAIL arb_grant: transfer %0d went to %0d required %0d", i, src, i % 2);
      else n_pass++;
      n_checks++;
      if ({neuron_addr, neuron_charge} !== ((i % 2 == 0) ? {host_addr, host_charge} : {dend_addr, dend_charge}))
        $display("FAIL arb_data: transfer %0d got %h", i, {neuron_addr, neuron_charge});
      else n_pass++;
      @(negedge clk);
      if (src == 0) begin host_addr = 8'($urandom_range(0, 255)); host_charge = 16'($urandom); end
      if (src == 1) begin dend_addr = 8'($urandom_range(0, 255)); dend_charge = 16'($urandom); end
      if (i == 3) dend_vld = 1'b0;
    end
    // host alone now, dend holds priority; stall and bring dend in
    neuron_rdy = 1'b0;
    #1;
    hold = {neuron_addr, neuron_charge};
    n_checks++;
    if ({neuron_vld, hold} !== {1'b1, host_addr, host_charge}) $display("FAIL stall_offer: got %h required %h", {neuron_vld, hold}, {1'b1, host_addr, host_charge});
    else n_pass++;
    @(negedge clk);
    dend_vld = 1'b1; dend_addr = 8'($urandom_range(0, 255)); dend_charge = 16'($urandom);
    for (int k = 0; k < 4; k++) begin
      #1;
      if ({neuron_vld, neuron_addr, neuron_charge} !== {1'b1, hold}) stable_bad++;
      if (dend_rdy || host_rdy) stable_bad++;
      @(negedge clk);
    end
    n_checks++;
    if (stable_bad !== 0) $display("FAIL stall_stable: %0d unstable cycles required 0", stable_bad);
    else n_pass++;
    neuron_rdy = 1'b1;
    #1;
    n_checks++;
    if ({host_rdy, neuron_addr, neuron_charge} !== {1'b1, hold}) $display("FAIL stall_release: got %h required %h", {host_rdy, neuron_addr, neuron_charge}, {1'b1, hold});
    else n_pass++;
    @(negedge clk);
    host_vld = 1'b0;
    #1;
    n_checks++;
    if ({dend_rdy, neuron_addr, neuron_charge} !== {1'b1, dend_addr, dend_charge}) $display("FAIL stall_next: got %h required %h", {dend_rdy, neuron_addr, neuron_charge}, {1'b1, dend_addr, dend_charge});
    else n_pass++;
    @(negedge clk);
    dend_vld = 1'b0;
  endtask

  task automatic test_arb_random();
    logic [23:0] exp_q_h[$];
    logic [23:0] exp_q_d[$];
    int sent_h, sent_d, got, bad, cyc;
    logic h_done, d_done;
    sent_h = 0; sent_d = 0; got = 0; bad = 0; cyc = 0;
    while (got < 20 && cyc < 2000) begin
      if (!host_vld && sent_h < 10 && $urandom_range(0, 1) == 1) begin
        host_addr = 8'($urandom_range(0, 255)); host_charge = 16'($urandom);
        host_vld = 1'b1; exp_q_h.push_back({host_addr, host_charge}); sent_h++;
      end
      if (!dend_vld && sent_d < 10 && $urandom_range(0, 1) == 1) begin
        dend_addr = 8'($urandom_range(0, 255)); dend_charge = 16'($urandom);
        dend_vld = 1'b1; exp_q_d.push_back({dend_addr, dend_charge}); sent_d++;
      end
      neuron_rdy = ($urandom_range(0, 3) != 0);
      h_done = 1'b0; d_done = 1'b0;
      #1;
      if (neuron_vld && neuron_rdy) begin
        if (host_rdy && !dend_rdy && exp_q_h.size() > 0 && {neuron_addr, neuron_charge} === exp_q_h[0]) begin
          void'(exp_q_h.pop_front()); h_done = 1'b1; got++;
        end else if (dend_rdy && !host_rdy && exp_q_d.size() > 0 && {neuron_addr, neuron_charge} === exp_q_d[0]) begin
          void'(exp_q_d.pop_front()); d_done = 1'b1; got++;
        end else begin
          bad++;
        end
      end
      @(negedge clk);
      if (h_done) host_vld = 1'b0;
      if (d_done) dend_vld = 1'b0;
      cyc++;
    end
    neuron_rdy = 1'b1;
    n_checks++;
    if (got !== 20) $display("FAIL sb_count: delivered %0d required 20", got);
    else n_pass++;
    n_checks++;
    if (bad !== 0) $display("FAIL sb_data: %0d wrong transfers required 0", bad);
    else n_pass++;
    n_checks++;
    if (exp_q_h.size() + exp_q_d.size() !== 0) $display("FAIL sb_leftover: %0d items left required 0", exp_q_h.size() + exp_q_d.size());
    else n_pass++;
  endtask

  task automatic test_cmd_noop();
    int bad;
    bad = 0;
    send_cmd(2'd3, 8'd9);
    repeat (6) begin
      if (busy || next_step || step_evt || !cmd_rdy) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad !== 0) $display("FAIL op3_ignored: %0d active cycles required 0", bad);
    else n_pass++;
    bad = 0;
    send_cmd(2'd0, 8'd0);
    repeat (6) begin
      if (busy || next_step || step_evt || !cmd_rdy) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad !== 0) $display("FAIL count0_ignored: %0d active cycles required 0", bad);
    else n_pass++;
    n_checks++;
    if (cur_time !== 16'(model_time)) $display("FAIL noop_time: cur_time=%0d required %0d", cur_time, model_time);
    else n_pass++;
  endtask

  task automatic test_clear_config();
    int hi, fall_at, gate_bad;
    hi = 0; fall_at = -1; gate_bad = 0;
    clear_done = 1'b0; neuron_rdy = 1'b1;
    send_cmd(2'd2, 8'd0);
    host_vld = 1'b1; host_addr = 8'h5a; host_charge = 16'sd3;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (clear_config) begin
        hi++;
        if (host_rdy || neuron_vld || clear_act) gate_bad++;
      end else if (fall_at < 0) begin
        fall_at = c;
        host_vld = 1'b0;
        clear_done = 1'b0;
        model_time = 0;
        n_checks++;
        if (cur_time !== 16'd0) $display("FAIL clear_time: cur_time=%0d required 0", cur_time);
        else n_pass++;
        n_checks++;
        if (cmd_rdy !== 1'b1) $display("FAIL clear_cmd_rdy: cmd_rdy=%b required 1", cmd_rdy);
        else n_pass++;
      end
      if (c == 5) clear_done = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (hi !== 6) $display("FAIL clear_width: clear_config high %0d cycles required 6", hi);
    else n_pass++;
    n_checks++;
    if (gate_bad !== 0) $display("FAIL clear_gate: %0d leaking cycles required 0", gate_bad);
    else n_pass++;
  endtask

  task automatic test_clear_early();
    int hi, cfg_hi;
    hi = 0; cfg_hi = 0;
    clear_done = 1'b1;
    send_cmd(2'd1, 8'd0);
    repeat (6) begin
      if (clear_act) hi++;
      if (clear_config) cfg_hi++;
      @(negedge clk);
    end
    clear_done = 1'b0;
    model_time = 0;
    n_checks++;
    if (hi !== 1) $display("FAIL clear_early_width: clear_act high %0d cycles required 1", hi);
    else n_pass++;
    n_checks++;
    if (cfg_hi !== 0) $display("FAIL clear_early_cfg: clear_config high %0d cycles required 0", cfg_hi);
    else n_pass++;
    n_checks++;
    if (cur_time4 !== 4'd0) $display("FAIL clear_early_time4: cur_time=%0d required 0", cur_time4);
    else n_pass++;
  endtask

  task automatic test_drain_extend();
    int xfers, evt_at, evt_cnt, last_busy;
    xfers = 0; evt_at = -1; evt_cnt = 0;
    last_busy = 11;   // last dend pulse at 9, step_done low on 10 and 11
    neuron_rdy = 1'b1; step_done = 1'b1;
    send_cmd(2'd0, 8'd1);
    for (int c = 0; c < 30; c++) begin
      dend_vld = (c >= 1 && c <= 9 && (c % 2) == 1);
      dend_addr = 8'($urandom_range(0, 255)); dend_charge = 16'($urandom);
      step_done = !(c == 10 || c == 11);
      #1;
      if (dend_vld && dend_rdy) xfers++;
      if (step_evt) begin
        evt_cnt++;
        if (evt_at < 0) evt_at = c;
      end
      @(negedge clk);
    end
    dend_vld = 1'b0; step_done = 1'b1;
    model_time = (model_time + 1) % 65536;
    n_checks++;
    if (xfers !== 5) $display("FAIL drain_xfers: %0d transfers required 5", xfers);
    else n_pass++;
    n_checks++;
    if (evt_cnt !== 1) $display("FAIL drain_evt_count: got %0d required 1", evt_cnt);
    else n_pass++;
    n_checks++;
    if (evt_at !== last_busy + QUIET + 1) $display("FAIL drain_evt_cycle: got %0d required %0d", evt_at, last_busy + QUIET + 1);
    else n_pass++;
    n_checks++;
    if (cur_time !== 16'(model_time)) $display("FAIL drain_time: cur_time=%0d required %0d", cur_time, model_time);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int needed;
    needed = (15 - (model_time % 16) + 16) % 16;
    if (needed > 0) run_steps(needed);
    n_checks++;
    if (cur_time4 !== 4'd15) $display("FAIL wrap_pre: cur_time=%0d required 15", cur_time4);
    else n_pass++;
    run_steps(1);
    n_checks++;
    if (cur_time4 !== 4'd0) $display("FAIL wrap_post: cur_time=%0d required 0", cur_time4);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int ns;
    ns = 0;
    step_done = 1'b1;
    send_cmd(2'd0, 8'd5);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL mid_busy: busy=%b required 1", busy);
    else n_pass++;
    reset = 1'b1; host_vld = 1'b1; dend_vld = 1'b1; neuron_rdy = 1'b1;
    #1;
    n_checks++;
    if ({neuron_vld, host_rdy, dend_rdy} !== 3'b000) $display("FAIL mid_gate: got %b required 000", {neuron_vld, host_rdy, dend_rdy});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({cmd_rdy, busy, next_step, step_evt, clear_act, clear_config} !== 6'b100000)
      $display("FAIL mid_reset_outs: got %b required 100000", {cmd_rdy, busy, next_step, step_evt, clear_act, clear_config});
    else n_pass++;
    n_checks++;
    if (cur_time !== 16'd0) $display("FAIL mid_reset_time: cur_time=%0d required 0", cur_time);
    else n_pass++;
    reset = 1'b0; host_vld = 1'b0; dend_vld = 1'b0;
    model_time = 0;
    repeat (40) begin
      if (next_step || step_evt) ns++;
      @(negedge clk);
    end
    n_checks++;
    if (ns !== 0) $display("FAIL mid_no_step: %0d pulses after reset required 0", ns);
    else n_pass++;
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    test_reset();
    test_arb_fair();
    test_arb_random();
    test_cmd_noop();
    run_steps(3);
    for (int r = 0; r < 3; r++) run_steps($urandom_range(1, 6));
    test_clear_config();
    test_clear_early();
    run_steps(2);
    test_drain_extend();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ucaspian_neuron_seq.md
UCASPIAN_NEURON_SEQ -- requirements
Module: ucaspian_neuron_seq

Interface
REQ-001 SHALL have parameter QUIET, default 3, number of consecutive quiet cycles that end a step.
REQ-002 SHALL have parameter TIME_W, default 16, width of the time-step counter.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cmd_op  in  2  command: 0 = step, 1 = clear activity, 2 = clear config, 3 = reserved.
- cmd_count  in  8  number of steps for op 0.
- cmd_vld / cmd_rdy  in / out  1 / 1  command handshake.
- host_addr, host_charge, host_vld / host_rdy  in, in, in / out  8, 16 signed, 1 / 1  host input fires.
- dend_addr, dend_charge, dend_vld / dend_rdy  in, in, in / out  8, 16 signed, 1 / 1  dendrite charges.
- neuron_addr, neuron_charge, neuron_vld / neuron_rdy  out, out, out / in  8, 16, 1 / 1  arbitrated stream to the neuron.
- clear_act, clear_config  out  1  neuron clear controls.
- clear_done  in  1  neuron clear complete.
- next_step  out  1  one-cycle step pulse to the neuron.
- step_done  in  1  neuron idle indication.
- cur_time  out  TIME_W  completed-step counter.
- step_evt  out  1  one-cycle pulse when a step command finishes.
- busy  out  1  high whenever the state is not IDLE.

Function
REQ-004 SHALL implement the FSM states IDLE, CLEAR, STEP, DRAIN, with transitions as stated in REQ-005 to REQ-011.
REQ-005 SHALL assert cmd_rdy only in IDLE; a handshake is cmd_vld && cmd_rdy.
REQ-006 On an op 1 or op 2 handshake, the FSM SHALL go to CLEAR next cycle:
- op 1: clear_act = 1.
- op 2: clear_config = 1.
- The asserted clear is held until clear_done is sampled high.
- The clear deasserts the following cycle, when the FSM returns to IDLE.
- cur_time is set to 0 on that same cycle.
REQ-007 Op 3 SHALL be accepted and ignored; the FSM stays in IDLE.
REQ-008 Op 0 with cmd_count = 0 SHALL be accepted with no next_step and no step_evt; the FSM stays in IDLE.
REQ-009 Op 0 with cmd_count = N > 0 SHALL:
- latch N into a remaining-step counter;
- enter STEP, which asserts next_step for exactly one cycle;
- then enter DRAIN.
REQ-010 In DRAIN, a quiet counter SHALL:
- increment on each cycle where step_done = 1, host_vld = 0, dend_vld = 0 and neuron_vld = 0;
- clear to 0 on any other cycle.
REQ-011 When the quiet counter reaches QUIET, the FSM SHALL:
- increment cur_time (modulo 2^TIME_W; all-ones wraps to 0);
- decrement the remaining count;
- go to STEP if the count is nonzero;
- otherwise go to IDLE and pulse step_evt for one cycle.
REQ-012 Arbitration SHALL be round-robin between host and dend:
- allowed in IDLE and DRAIN, gated off in CLEAR and STEP;
- when gated, host_rdy = dend_rdy = neuron_vld = 0.
REQ-013 The grant SHALL lock on the selected requester while neuron_vld && !neuron_rdy; addr and charge stay stable until the transfer completes.
REQ-014 After each completed transfer, priority SHALL pass to the other requester.
- After reset, host has priority.
- If only one requester is valid, it is granted regardless of priority.
REQ-015 The output stream SHALL be a combinational mux of the granted requester:
- neuron_vld = granted vld;
- granted rdy = neuron_rdy;
- the non-granted rdy = 0.
REQ-016 next_step, step_evt, clear_act and clear_config SHALL be registered outputs.
REQ-017 A clear_done that is already high on entry to CLEAR SHALL still hold the clear for at least one cycle.

Reset
REQ-018 Reset SHALL take effect on the next rising edge and override any in-progress operation. Afterwards:
- state = IDLE, quiet = 0, remaining = 0, priority = host, grant lock released;
- cur_time = 0;
- cmd_rdy = 1 and busy = 0;
- next_step = step_evt = clear_act = clear_config = 0;
- neuron_vld = host_rdy = dend_rdy = 0 while reset is asserted.

Verification
REQ-019 Step sequencing: op 0, count 3, step_done tied 1, no traffic -> three next_step pulses each (QUIET+1) cycles apart, cur_time 0->3, one step_evt, then cmd_rdy = 1.
REQ-020 Clear handshake: op 2 with clear_done returned 5 cycles after clear_config rises -> clear_config high exactly 6 cycles, cur_time = 0, cmd_rdy high the cycle after clear_config falls.
REQ-021 Fair arbitration: host_vld and dend_vld both held high, neuron_rdy = 1 -> grants alternate host, dend, host, dend; with neuron_rdy stalled 4 cycles, neuron_addr/neuron_charge stay constant throughout.
REQ-022 Drain extension: during DRAIN, dend_vld pulses every 2 cycles for 10 cycles -> no step completion until QUIET quiet cycles follow the last transfer.
REQ-023 Counter wrap: TIME_W = 4, cur_time = 15, op 0 count 1 -> cur_time = 0 with step_evt asserted.
REQ-024 Reset mid-operation: reset during DRAIN of a count-5 step -> all outputs reach reset values next cycle, and no further next_step is issued.
